// File: rtl/iris_clause_eval.sv
// iris_clause_eval: evaluates 12 Tsetlin-machine clauses (3 classes x 2 polarities x 2) per feature vector.
// Optional macro IRIS_CE_PARALLEL_EN: all clauses evaluated in one cycle instead of one clause per cycle.
module iris_clause_eval #(
    parameter int N_FEAT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [2*N_FEAT-1:0] cfg_data,
    output logic                cfg_ready,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_FEAT-1:0]   features,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          pos_clause_1,
    output logic [1:0]          neg_clause_1,
    output logic [1:0]          pos_clause_2,
    output logic [1:0]          neg_clause_2,
    output logic [1:0]          pos_clause_3,
    output logic [1:0]          neg_clause_3
);

    localparam int N_LIT    = 2 * N_FEAT;
    localparam int N_CLAUSE = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [N_FEAT-1:0]    feat_r;
    logic [N_LIT-1:0]     mask_r [N_CLAUSE];
    logic [N_CLAUSE-1:0]  res_r;
    logic [N_CLAUSE-1:0]  res_view_s;
    logic                 accept_s;
    logic                 cfg_hit_s;

    // A clause is the AND of its included literals; an empty clause reads as 0 at inference.
    function automatic logic clause_eval(input logic [N_LIT-1:0] mask, input logic [N_FEAT-1:0] f);
        logic [N_LIT-1:0] lits;
        lits = {~f, f};
        return (|mask) & (&(lits | ~mask));
    endfunction

    assign accept_s  = (state_r == ST_IDLE) && in_valid;
    assign cfg_hit_s = (state_r == ST_IDLE) && cfg_we && (cfg_addr < 4'd12);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Include-mask bank: cleared on reset, writable only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CLAUSE; k++) begin
                mask_r[k] <= {N_LIT{1'b0}};
            end
        end else if (cfg_hit_s) begin
            mask_r[cfg_addr] <= cfg_data;
        end
    end

`ifdef IRIS_CE_PARALLEL_EN
    logic [N_CLAUSE-1:0] par_res_s;

    // All clauses at once from the latched vector; masks cannot change while DONE.
    always_comb begin
        par_res_s = {N_CLAUSE{1'b0}};
        for (int k = 0; k < N_CLAUSE; k++) begin
            par_res_s[k] = clause_eval(mask_r[k], feat_r);
        end
    end

    // Latch the vector on acceptance; capture results in DONE so they persist afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat_r <= {N_FEAT{1'b0}};
            res_r  <= {N_CLAUSE{1'b0}};
        end else if (accept_s) begin
            feat_r <= features;
        end else if (state_r == ST_DONE) begin
            res_r <= par_res_s;
        end
    end

    assign res_view_s = (state_r == ST_DONE) ? par_res_s : res_r;

    // Next-state: IDLE -> DONE -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_s = ST_DONE;
                else          state_s = ST_IDLE;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end
`else
    logic [3:0] cnt_r;

    // Latch the vector on acceptance, then resolve one clause per EVAL cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat_r <= {N_FEAT{1'b0}};
            cnt_r  <= 4'd0;
            res_r  <= {N_CLAUSE{1'b0}};
        end else if (accept_s) begin
            feat_r <= features;
            cnt_r  <= 4'd0;
        end else if (state_r == ST_EVAL) begin
            res_r[cnt_r] <= clause_eval(mask_r[cnt_r], feat_r);
            cnt_r        <= cnt_r + 4'd1;
        end
    end

    assign res_view_s = res_r;

    // Next-state: IDLE -> EVAL (12 cycles) -> DONE -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_s = ST_EVAL;
                else          state_s = ST_IDLE;
            end
            ST_EVAL: begin
                if (cnt_r == 4'd11) state_s = ST_DONE;
                else                state_s = ST_EVAL;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end
`endif

    assign in_ready  = (state_r == ST_IDLE);
    assign cfg_ready = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);

    // idx = 4*(class-1) + 2*pol + j
    assign pos_clause_1 = res_view_s[1:0];
    assign neg_clause_1 = res_view_s[3:2];
    assign pos_clause_2 = res_view_s[5:4];
    assign neg_clause_2 = res_view_s[7:6];
    assign pos_clause_3 = res_view_s[9:8];
    assign neg_clause_3 = res_view_s[11:10];

endmodule

// File: tb/tb_iris_clause_eval.sv
// Self-checking bench for iris_clause_eval: literal-based behavioural clause model plus directed and random vectors.
module tb_iris_clause_eval;

`ifdef IRIS_CE_PARALLEL_EN
    localparam int LAT    = 0;   // edges after the acceptance edge until out_valid is seen
    localparam int PER    = 2;
    localparam int RST_AT = 0;
`else
    localparam int LAT    = 12;
    localparam int PER    = 14;
    localparam int RST_AT = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_ready;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] features;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  pos_clause_1, neg_clause_1, pos_clause_2, neg_clause_2, pos_clause_3, neg_clause_3;

    iris_clause_eval #(.N_FEAT(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .features(features),
        .out_valid(out_valid), .out_ready(out_ready),
        .pos_clause_1(pos_clause_1), .neg_clause_1(neg_clause_1),
        .pos_clause_2(pos_clause_2), .neg_clause_2(neg_clause_2),
        .pos_clause_3(pos_clause_3), .neg_clause_3(neg_clause_3)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          n_done = 0;
    logic [31:0] model_mask [12];
    logic [11:0] exp_res = 12'h000;
    logic [11:0] last_got;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk every included literal; f[b] for b<16, ~f[b-16] otherwise; empty clause is 0.
    function automatic logic [11:0] model_eval(input logic [15:0] f);
        logic [11:0] r;
        logic        ok;
        logic        lit;
        for (int k = 0; k < 12; k++) begin
            ok = (model_mask[k] != 32'd0);
            for (int b = 0; b < 32; b++) begin
                if (model_mask[k][b]) begin
                    lit = (b < 16) ? f[b] : !f[b - 16];
                    if (!lit) ok = 1'b0;
                end
            end
            r[k] = ok;
        end
        return r;
    endfunction

    function automatic logic [1:0] port_of(input int c, input int p);
        case (2 * (c - 1) + p)
            0: return pos_clause_1;
            1: return neg_clause_1;
            2: return pos_clause_2;
            3: return neg_clause_2;
            4: return pos_clause_3;
            5: return neg_clause_3;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] rand_mask();
        if ($urandom_range(0, 1) == 0) return $urandom & $urandom & $urandom & $urandom;
        else                           return $urandom & $urandom & $urandom;
    endfunction

    // Single compare process: every cycle results are valid, ports must match the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_done++;
            for (int c = 1; c <= 3; c++) begin
                for (int p = 0; p < 2; p++) begin
                    int idx;
                    idx = 4 * (c - 1) + 2 * p;
                    check($sformatf("clause_c%0d_%s", c, p ? "neg" : "pos"), port_of(c, p),
                          {exp_res[idx + 1], exp_res[idx]});
                end
            end
            check("in_ready_in_done", in_ready, 0);
            check("cfg_ready_in_done", cfg_ready, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        check("cfg_ready_idle", cfg_ready, 1);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        if (a < 4'd12) model_mask[a] = d;
    endtask

    task automatic run_vector(input logic [15:0] f, input int hold, input bit we,
                              input logic [3:0] a, input logic [31:0] d, input bit junk);
        int n;
        check("in_ready_idle", in_ready, 1);
        features = f; in_valid = 1'b1;
        if (we) begin cfg_we = 1'b1; cfg_addr = a; cfg_data = d; end
        if (we && a < 4'd12) model_mask[a] = d;
        exp_res = model_eval(f);
        tick();
        in_valid = 1'b0; cfg_we = 1'b0; features = 16'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            if (junk) begin cfg_we = 1'b1; cfg_addr = 4'($urandom_range(0, 11)); cfg_data = $urandom; end
            tick();
            n++;
        end
        cfg_we = 1'b0;
        check("latency", n, LAT);
        last_got = {neg_clause_3, pos_clause_3, neg_clause_2, pos_clause_2, neg_clause_1, pos_clause_1};
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                cfg_we = 1'b1;
                cfg_addr = (i % 2 == 0) ? 4'd0 : 4'($urandom_range(0, 11));
                cfg_data = $urandom | 32'h0001_0000;
            end
            tick();
            check("held_in_done", out_valid, 1);
        end
        cfg_we = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n, nacc, last_acc, acc_edge, nd0;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 32'd0;
        in_valid = 1'b0; features = 16'd0; out_ready = 1'b0;
        for (int k = 0; k < 12; k++) model_mask[k] = 32'd0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_ports", {neg_clause_3, pos_clause_3, neg_clause_2, pos_clause_2, neg_clause_1, pos_clause_1}, 12'h000);
        rst = 1'b0;
        tick();

        run_vector(16'hFFFF, 0, 1'b0, 4'd0, 32'd0, 1'b0);
        check("empty_clauses", last_got, 12'h000);

        do_write(4'd0, 32'h0000_0001);
        run_vector(16'h0001, 0, 1'b0, 4'd0, 32'd0, 1'b0);
        check("c0_f1_pos1", last_got, 12'h001);
        run_vector(16'h0000, 0, 1'b0, 4'd0, 32'd0, 1'b0);
        check("c0_f0_pos1", last_got, 12'h000);

        do_write(4'd5, 32'h0008_0000);
        run_vector(16'h0000, 5, 1'b0, 4'd0, 32'd0, 1'b1);
        check("c5_pos2_10", last_got, 12'h020);
        run_vector(16'h0001, 0, 1'b0, 4'd0, 32'd0, 1'b0);
        check("mask_kept_after_done_write", last_got[1:0], 2'b01);

        do_write(4'd13, 32'hFFFF_FFFF);
        do_write(4'd12, 32'h0000_0002);
        run_vector(16'h0000, 0, 1'b1, 4'd0, 32'h0001_0000, 1'b0);
        check("same_cycle_write", last_got, 12'h021);

        features = 16'h0001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (RST_AT) tick();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_ports", {neg_clause_3, pos_clause_3, neg_clause_2, pos_clause_2, neg_clause_1, pos_clause_1}, 12'h000);
        check("midrst_in_ready", in_ready, 1);
        for (int k = 0; k < 12; k++) model_mask[k] = 32'd0;
        tick();
        rst = 1'b0;
        n = 0;
        repeat (20) begin tick(); if (out_valid) n++; end
        check("no_valid_after_rst", n, 0);
        check("in_ready_after_rst", in_ready, 1);
        run_vector(16'h0001, 0, 1'b0, 4'd0, 32'd0, 1'b0);
        check("mask_cleared_by_rst", last_got, 12'h000);

        for (int k = 0; k < 12; k++) do_write(4'(k), rand_mask());
        for (int v = 0; v < 40; v++) begin
            if ($urandom_range(0, 1) == 1) do_write(4'($urandom_range(0, 15)), rand_mask());
            run_vector(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), rand_mask(), 1'($urandom_range(0, 1)));
        end

        out_ready = 1'b1; in_valid = 1'b1; features = 16'($urandom);
        nacc = 0; last_acc = -1; nd0 = n_done;
        for (int c = 0; c < 30 * PER && nacc < 20; c++) begin
            if (in_ready) begin
                exp_res = model_eval(features);
                acc_edge = cyc + 1;
                if (last_acc >= 0) check("b2b_spacing", acc_edge - last_acc, PER);
                last_acc = acc_edge;
                nacc++;
                tick();
                features = 16'($urandom);
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        repeat (LAT + 3) tick();
        out_ready = 1'b0;
        check("b2b_accepts", nacc, 20);
        check("b2b_done_count", n_done - nd0, nacc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iris_clause_eval.md
# iris_clause_eval

Clause-evaluation stage of the Iris Tsetlin-machine inference path. Accepts one booleanized feature vector per handshake and evaluates the 12 stored clauses: 3 classes × 2 polarities × 2 clauses. It presents the results as the six 2-bit `pos_clause_k`/`neg_clause_k` vectors consumed directly by the sum-and-threshold classifier. Clause include masks live in an internal register bank written through a configuration port.

## Interface
- `N_FEAT`, 16: booleanized feature bits (4 Iris features × 4 thermometer bits); literal vector width is 2·N_FEAT.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: include-mask write strobe.
- `cfg_addr` in 4: clause index 0–11; 12–15 are ignored.
- `cfg_data` in 2·N_FEAT: include mask for the addressed clause.
- `cfg_ready` out 1: high only in IDLE; writes are accepted only when high.
- `in_valid` in 1: feature vector valid.
- `in_ready` out 1: stage can accept a vector.
- `features` in N_FEAT: booleanized input.
- `out_valid` out 1: clause results valid.
- `out_ready` in 1: downstream accepts results.
- `pos_clause_1`, `neg_clause_1`, `pos_clause_2`, `neg_clause_2`, `pos_clause_3`, `neg_clause_3`: each out 2, clause outputs for classes 1–3.

## Operation
- Literal vector `L = {~f, f}`:
  - bit i (i < N_FEAT) = `f[i]`.
  - bit N_FEAT+i = `~f[i]`.
  - `f` is the latched feature register.
- Clause index mapping:
  - `idx = 4·(class−1) + 2·pol + j`, where pol 0 = positive and pol 1 = negative.
  - The result goes to bit j of the matching port.
  - Example: idx 5 → `pos_clause_2[1]`; idx 11 → `neg_clause_3[1]`.
- Clause value = AND of `L[b]` over every b where `mask[idx][b]` = 1.
- An empty mask (all zeros) yields 0 (inference convention).
- FSM states:
  - **IDLE**:
    - `in_ready`=1, `cfg_ready`=1.
    - On `in_valid`: latch `features`, clear clause counter, go to EVAL.
    - `cfg_we` with a valid address writes the mask; an invalid address is dropped.
    - If `cfg_we` and `in_valid` occur in the same cycle, both take effect: the write lands, and evaluation of the new vector uses the updated mask.
  - **EVAL**:
    - Evaluates clause `cnt` each cycle and stores the bit in the result register.
    - `cnt` increments 0→11; after `cnt`=11, go to DONE.
    - `cfg_we` is ignored.
  - **DONE**:
    - `out_valid`=1; result registers are stable.
    - On `out_ready`, go to IDLE.
    - `in_ready`=0: there is no overlap of input acceptance and output hold.
- Result registers hold their last values after leaving DONE.
- While EVAL builds a new result, ports may show partial updates; only values with `out_valid` high are meaningful.

## Timing
- Reset (async assert, synchronous deassert by the surrounding reset logic):
  - State = IDLE; `cnt`=0.
  - All 12 masks = 0; feature register = 0.
  - All clause outputs = 2'b00; `out_valid`=0.
  - `in_ready`=1 and `cfg_ready`=1 while `rst` is low.
- Latency: input handshake at edge 0 → `out_valid` high after edge 12 (12 cycles).
- Throughput with `out_ready` tied high: 14 cycles per vector. The out handshake at edge 13 returns to IDLE; the next acceptance is at edge 14.
- Reset mid-EVAL or mid-DONE:
  - Aborts immediately; `out_valid` drops.
  - The pending vector is lost, and masks are cleared.
- `out_ready` held low: DONE persists indefinitely and all outputs are held.

## Configuration
- `IRIS_CE_PARALLEL_EN` defined:
  - The EVAL state is removed; all 12 clauses are evaluated combinationally from the latched features.
  - IDLE→DONE on acceptance, so `out_valid` rises 1 cycle after the input handshake.
  - Throughput is 2 cycles per vector.
- Undefined: the serial one-clause-per-cycle datapath (12-cycle latency) is used.
- Both builds:
  - Produce bit-identical clause outputs.
  - Use identical ports, and identical reset and configuration behaviour.

## Test plan
- Reset, no mask writes, `features`=16'hFFFF → after 12 cycles, `out_valid`=1 and all six clause ports = 2'b00 (empty clauses).
- Write `cfg_addr`=0 with `cfg_data` bit 0 set:
  - `features`=16'h0001 → `pos_clause_1`=2'b01.
  - `features`=16'h0000 → `pos_clause_1`=2'b00.
- Write `cfg_addr`=5 with `cfg_data` bit N_FEAT+3 set, then `features`=16'h0000 → `pos_clause_2`=2'b10; all other ports = 00.
- Hold `out_ready` low for 5 cycles in DONE:
  - `out_valid` stays 1, outputs are unchanged, and `in_ready`=0.
  - A `cfg_we` during this window leaves the mask unchanged (verify on the next vector).
- Assert `rst` on the 6th EVAL cycle:
  - `out_valid` never rises; outputs are 00; `in_ready`=1 after release.
  - The previously written clause-0 mask now yields 0.
- Run back-to-back vectors with `out_ready`=1 → accepted every 14 cycles (every 2 with `IRIS_CE_PARALLEL_EN`), with results matching a reference model.
